piece_drop_ctrl: RTL and testbench
==================================

// Module: piece_drop_ctrl
// PURPOSE
//   Gravity/placement engine feeding main_FSM: moves the active piece anchor down on a
//   gravity tick and left/right on player pulses, validating each move with the board
//   collision checker via a req/ack handshake. Produces the placed and game_over
//   inputs that main_FSM consumes; runs only while main_FSM reports the PLAY state.
// PARAMETERS
//   BOARD_W     10    board columns; anchor x range 0..BOARD_W-1
//   BOARD_H     20    board rows; anchor y range 0..BOARD_H-1 (0 = top)
//   SPAWN_X     4     anchor column for each new piece
//   TICK_DIV    50    in_clka cycles per gravity step (>=2)
//   PLAY_STATE  3'd1  main_FSM state code in which this block is active
// PORTS
//   in_clka     in   1  sole clock, all logic on rising edge
//   restart     in   1  synchronous active-high reset
//   state       in   3  main_FSM state
//   move_left   in   1  one-cycle move-left request
//   move_right  in   1  one-cycle move-right request
//   chk_req     out  1  collision query valid, held until chk_ack
//   chk_x       out  4  queried anchor column, stable while chk_req
//   chk_y       out  5  queried anchor row, stable while chk_req
//   chk_ack     in   1  checker response valid (1 cycle, >=1 cycle after req)
//   chk_hit     in   1  1 = queried position collides; valid with chk_ack
//   piece_x     out  4  committed anchor column
//   piece_y     out  5  committed anchor row
//   placed      out  1  one-cycle pulse: piece locked
//   game_over   out  1  sticky: spawn position blocked
// BEHAVIOUR
//   Reset: all outputs 0 except piece_x=SPAWN_X; FSM=IDLE; tick counter=0.
//   States: IDLE, SPAWN_CHK, FALL, MOVE_CHK, DROP_CHK, PLACE, OVER.
//   IDLE: state==PLAY_STATE -> SPAWN_CHK, query (SPAWN_X,0).
//   SPAWN_CHK: ack&hit -> OVER, game_over=1 next cycle. Ack&!hit -> piece_x=SPAWN_X,
//     piece_y=0, counter=0, -> FALL.
//   FALL: counter increments each cycle. counter==TICK_DIV-1 -> counter=0:
//     piece_y==BOARD_H-1 -> PLACE with no query; else query (x,y+1), -> DROP_CHK.
//     Otherwise move_left xor move_right -> query (x-1,y) or (x+1,y), -> MOVE_CHK.
//     Left at x==0 or right at x==BOARD_W-1: dropped, no query.
//   Gravity expiry beats a move in the same cycle; that move is dropped.
//   Left and right together: both dropped.
//   Move pulses arriving outside FALL are dropped, not queued.
//   Counter frozen outside FALL; keeps its value across MOVE_CHK.
//   MOVE_CHK: ack&!hit -> piece_x updated; either way -> FALL.
//   DROP_CHK: ack&!hit -> piece_y+1, -> FALL. Ack&hit -> PLACE.
//   PLACE: placed=1 exactly one cycle; then SPAWN_CHK if state==PLAY_STATE, else IDLE.
//   OVER: game_over held 1, no queries issued; cleared only by restart.
//   Handshake: chk_req rises with chk_x/chk_y valid; held until the ack cycle; low the
//     cycle after. At most one query outstanding; chk_ack while chk_req=0 ignored.
//   state leaves PLAY_STATE during a query: handshake completes, result discarded,
//     -> IDLE. Outside a query: -> IDLE next cycle.
//   IDLE/OVER keep piece_x/piece_y.
//   placed and game_over never both 1 in one cycle.
//   restart mid-handshake: chk_req drops next edge; late acks ignored.
// TESTING (TICK_DIV=4, checker model acks 2 cycles after req)
//   1 restart 1 cycle then state=1, checker never hits -> query (4,0); piece_y 0->1->2
//     every 4+2 cycles; placed stays 0.
//   2 Free fall to y=19 -> next tick gives placed=1 for 1 cycle with no query, then
//     spawn query (4,0).
//   3 Checker hits at (4,5) -> DROP_CHK ack&hit, placed pulse, piece_y stays 4.
//   4 Spawn query hit -> game_over=1 sticky; no further chk_req; restart clears to 0.
//   5 move_left at x=4 -> x=3; move_left at x=0 -> no req. Left+right together -> x
//     unchanged. Move on tick-expiry cycle -> only drop query.
//   6 state->0 while chk_req=1 -> req held until ack, piece_x/y unchanged, FSM IDLE;
//     restart mid-handshake -> req low next cycle, stray ack ignored.

Source files
------------

// File: rtl/piece_drop_ctrl.sv
// -----------------------------------------------------------------------------
// piece_drop_ctrl
//   Gravity/placement engine for the active piece. While main_FSM reports the
//   play state it spawns a piece, lets it fall one row per gravity tick, and
//   shifts it left/right on player pulses. Every move is validated by an
//   external collision checker through a req/ack handshake before it is
//   committed. Produces the one-cycle placed pulse and the sticky game_over
//   flag consumed by main_FSM.
//
// Ports
//   in_clka     in   sole clock, rising edge
//   restart     in   synchronous active-high reset
//   state[2:0]  in   main_FSM state; this block runs only in PLAY_STATE
//   move_left   in   one-cycle move-left request
//   move_right  in   one-cycle move-right request
//   chk_req     out  collision query valid, held until chk_ack
//   chk_x[3:0]  out  queried anchor column
//   chk_y[4:0]  out  queried anchor row
//   chk_ack     in   checker response valid (one cycle)
//   chk_hit     in   queried position collides; valid with chk_ack
//   piece_x     out  committed anchor column
//   piece_y     out  committed anchor row
//   placed      out  one-cycle pulse when the piece locks
//   game_over   out  sticky, spawn position blocked
// -----------------------------------------------------------------------------
module piece_drop_ctrl #(
    parameter int         BOARD_W    = 10,
    parameter int         BOARD_H    = 20,
    parameter int         SPAWN_X    = 4,
    parameter int         TICK_DIV   = 50,
    parameter logic [2:0] PLAY_STATE = 3'd1
) (
    input  logic       in_clka,
    input  logic       restart,
    input  logic [2:0] state,
    input  logic       move_left,
    input  logic       move_right,
    output logic       chk_req,
    output logic [3:0] chk_x,
    output logic [4:0] chk_y,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic [3:0] piece_x,
    output logic [4:0] piece_y,
    output logic       placed,
    output logic       game_over
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]       X_SPAWN  = 4'(SPAWN_X);
    localparam logic [3:0]       X_MAX    = 4'(BOARD_W - 1);
    localparam logic [4:0]       Y_MAX    = 5'(BOARD_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN_CHK,
        S_FALL,
        S_MOVE_CHK,
        S_DROP_CHK,
        S_PLACE,
        S_OVER
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       px_q, px_d;
    logic [4:0]       py_q, py_d;
    logic [3:0]       qx_q, qx_d;
    logic [4:0]       qy_q, qy_d;
    // Set when play was left while a query is outstanding, so the result is
    // discarded even if play resumes before the ack arrives.
    logic             abort_q, abort_d;
    logic             play;

    assign play = (state == PLAY_STATE);

    // State and datapath registers
    always_ff @(posedge in_clka) begin
        if (restart) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            px_q    <= X_SPAWN;
            py_q    <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            px_q    <= px_d;
            py_q    <= py_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            abort_q <= abort_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        px_d    = px_q;
        py_d    = py_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        abort_d = abort_q;

        case (fsm_q)
            S_IDLE: begin
                if (play) begin
                    fsm_d = S_SPAWN_CHK;
                    qx_d  = X_SPAWN;
                    qy_d  = '0;
                end
            end

            S_SPAWN_CHK, S_MOVE_CHK, S_DROP_CHK: begin
                if (!play) begin
                    abort_d = 1'b1;
                end
                if (chk_ack) begin
                    abort_d = 1'b0;
                    if (abort_q || !play) begin
                        fsm_d = S_IDLE;
                    end else if (!chk_hit) begin
                        // Every query differs from the committed anchor only
                        // in the moved coordinate, so committing both is exact.
                        px_d  = qx_q;
                        py_d  = qy_q;
                        fsm_d = S_FALL;
                        if (fsm_q == S_SPAWN_CHK) begin
                            cnt_d = '0;
                        end
                    end else if (fsm_q == S_SPAWN_CHK) begin
                        fsm_d = S_OVER;
                    end else if (fsm_q == S_DROP_CHK) begin
                        fsm_d = S_PLACE;
                    end else begin
                        fsm_d = S_FALL;
                    end
                end
            end

            S_FALL: begin
                if (!play) begin
                    fsm_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Gravity wins over any move pulse in the same cycle.
                    cnt_d = '0;
                    if (py_q == Y_MAX) begin
                        fsm_d = S_PLACE;
                    end else begin
                        qx_d  = px_q;
                        qy_d  = py_q + 5'd1;
                        fsm_d = S_DROP_CHK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (move_left && !move_right && px_q != 4'd0) begin
                        qx_d  = px_q - 4'd1;
                        qy_d  = py_q;
                        fsm_d = S_MOVE_CHK;
                    end else if (move_right && !move_left && px_q != X_MAX) begin
                        qx_d  = px_q + 4'd1;
                        qy_d  = py_q;
                        fsm_d = S_MOVE_CHK;
                    end
                end
            end

            S_PLACE: begin
                if (play) begin
                    fsm_d = S_SPAWN_CHK;
                    qx_d  = X_SPAWN;
                    qy_d  = '0;
                end else begin
                    fsm_d = S_IDLE;
                end
            end

            S_OVER: begin
                fsm_d = S_OVER;
            end

            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded straight from registers
    always_comb begin
        chk_req   = (fsm_q == S_SPAWN_CHK) || (fsm_q == S_MOVE_CHK) ||
                    (fsm_q == S_DROP_CHK);
        chk_x     = qx_q;
        chk_y     = qy_q;
        piece_x   = px_q;
        piece_y   = py_q;
        placed    = (fsm_q == S_PLACE);
        game_over = (fsm_q == S_OVER);
    end

endmodule

// File: tb/tb_piece_drop_ctrl.sv
module tb_piece_drop_ctrl;

    localparam int TICK    = 4;
    localparam int BW      = 10;
    localparam int BH      = 20;
    localparam int SPAWN   = 4;

    logic       clk = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] state_in = 3'd0;
    logic       ml = 1'b0, mr = 1'b0;
    logic       ack = 1'b0, hit = 1'b0;
    logic       chk_req, placed, game_over;
    logic [3:0] chk_x, piece_x;
    logic [4:0] chk_y, piece_y;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    piece_drop_ctrl #(
        .BOARD_W(BW), .BOARD_H(BH), .SPAWN_X(SPAWN), .TICK_DIV(TICK), .PLAY_STATE(3'd1)
    ) dut (
        .in_clka(clk), .restart(restart), .state(state_in),
        .move_left(ml), .move_right(mr),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y),
        .chk_ack(ack), .chk_hit(hit),
        .piece_x(piece_x), .piece_y(piece_y),
        .placed(placed), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- collision checker model ----------------
    bit blocked [BW][BH];
    int req_cycles = 0;
    bit stray_ack = 0;

    task automatic clear_board();
        for (int x = 0; x < BW; x++)
            for (int y = 0; y < BH; y++)
                blocked[x][y] = 0;
    endtask

    // ---------------- behavioural reference model ----------------
    // The game seen from outside: where the piece is, what is being asked of
    // the checker, and how many gravity-relevant cycles have elapsed.
    typedef enum int {M_IDLE, M_WAIT_SPAWN, M_FALLING, M_WAIT_SIDE, M_WAIT_DROP, M_LOCK, M_DEAD} mphase_t;
    mphase_t m_phase = M_IDLE;
    int m_x = SPAWN, m_y = 0, m_qx = 0, m_qy = 0, m_ticks = 0;
    bit m_stale = 0;

    task automatic ask(mphase_t ph, int x, int y);
        m_phase = ph;
        m_qx = x;
        m_qy = y;
    endtask

    task automatic model_edge(bit rst, bit play, bit l, bit r, bit a, bit h);
        int nx;
        if (rst) begin
            m_phase = M_IDLE; m_x = SPAWN; m_y = 0; m_qx = 0; m_qy = 0;
            m_ticks = 0; m_stale = 0;
            return;
        end
        if (m_phase inside {M_WAIT_SPAWN, M_WAIT_SIDE, M_WAIT_DROP}) begin
            if (!play) m_stale = 1;
            if (a) begin
                if (m_stale) m_phase = M_IDLE;
                else if (!h) begin
                    m_x = m_qx;
                    m_y = m_qy;
                    if (m_phase == M_WAIT_SPAWN) m_ticks = 0;
                    m_phase = M_FALLING;
                end else if (m_phase == M_WAIT_SPAWN) m_phase = M_DEAD;
                else if (m_phase == M_WAIT_DROP) m_phase = M_LOCK;
                else m_phase = M_FALLING;
                m_stale = 0;
            end
            return;
        end
        case (m_phase)
            M_IDLE: if (play) ask(M_WAIT_SPAWN, SPAWN, 0);
            M_LOCK: if (play) ask(M_WAIT_SPAWN, SPAWN, 0); else m_phase = M_IDLE;
            M_FALLING: begin
                if (!play) m_phase = M_IDLE;
                else begin
                    m_ticks++;
                    if (m_ticks == TICK) begin
                        m_ticks = 0;
                        if (m_y == BH - 1) m_phase = M_LOCK;
                        else ask(M_WAIT_DROP, m_x, m_y + 1);
                    end else if (l != r) begin
                        nx = l ? m_x - 1 : m_x + 1;
                        if (nx >= 0 && nx < BW) ask(M_WAIT_SIDE, nx, m_y);
                    end
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [20:0] model_vec();
        bit req;
        req = (m_phase inside {M_WAIT_SPAWN, M_WAIT_SIDE, M_WAIT_DROP});
        return {req, req ? 4'(m_qx) : 4'd0, req ? 5'(m_qy) : 5'd0, 4'(m_x), 5'(m_y),
                m_phase == M_LOCK, m_phase == M_DEAD};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {chk_req, chk_req ? chk_x : 4'd0, chk_req ? chk_y : 5'd0, piece_x, piece_y,
                placed, game_over};
    endfunction

    // One clock: checker answers, model advances, edge, settle.
    task automatic step();
        if (chk_req === 1'b1) req_cycles++; else req_cycles = 0;
        ack = 1'b0;
        hit = 1'b0;
        if (chk_req === 1'b1 && req_cycles == 2) begin
            ack = 1'b1;
            hit = (chk_x < 4'(BW) && chk_y < 5'(BH)) ? blocked[chk_x][chk_y] : 1'b1;
            req_cycles = 0;
        end
        if (stray_ack && chk_req !== 1'b1) begin
            ack = 1'b1;
            hit = 1'b0;
        end
        model_edge(restart, state_in == 3'd1, ml, mr, ack, hit);
        @(posedge clk);
        #1;
        ml = 1'b0;
        mr = 1'b0;
        stray_ack = 0;
        cyc++;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // Advance until the model is falling with the given tick age.
    task automatic wait_fall(int age, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_phase == M_FALLING && m_ticks == age) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        state_in = 3'd0;
        do_restart();
        tests++;
        if ({chk_req, chk_x, chk_y, piece_x, piece_y, placed, game_over} !==
            {1'b0, 4'd0, 5'd0, 4'd4, 5'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values got=%b_%0d_%0d_%0d_%0d_%b_%b required=0_0_0_4_0_0_0",
                     chk_req, chk_x, chk_y, piece_x, piece_y, placed, game_over);
        end
        step();
        tests++;
        if (dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL reset_idle got=%h required=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_free_fall();
        int t1 = -1, t2 = -1;
        bit done = 0;
        clear_board();
        do_restart();
        state_in = 3'd1;
        step();
        tests++;
        if (!(chk_req === 1'b1 && chk_x === 4'd4 && chk_y === 5'd0)) begin
            fails++;
            $display("FAIL spawn_query got=%b(%0d,%0d) required=1(4,0)", chk_req, chk_x, chk_y);
        end
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++;
                $display("FAIL free_fall cyc=%0d got=%h required=%h", cyc, dut_vec(), model_vec());
            end
            if (t1 < 0 && piece_y === 5'd1) t1 = cyc;
            if (t2 < 0 && piece_y === 5'd2) t2 = cyc;
            if (placed === 1'b1) begin
                done = 1;
                tests++;
                if (!(piece_y === 5'd19 && chk_req === 1'b0)) begin
                    fails++;
                    $display("FAIL bottom_place got y=%0d req=%b required y=19 req=0", piece_y, chk_req);
                end
                step();
                tests++;
                if (!(placed === 1'b0 && chk_req === 1'b1 && chk_x === 4'd4 && chk_y === 5'd0)) begin
                    fails++;
                    $display("FAIL respawn got placed=%b req=%b (%0d,%0d) required 0 1 (4,0)",
                             placed, chk_req, chk_x, chk_y);
                end
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL free_fall_timeout got no placed pulse required placed pulse");
        end
        tests++;
        if (t1 < 0 || t2 - t1 != TICK + 2) begin
            fails++;
            $display("FAIL fall_period got=%0d required=%0d", t2 - t1, TICK + 2);
        end
    endtask

    task automatic test_hit_place();
        bit done = 0;
        clear_board();
        blocked[4][5] = 1;
        do_restart();
        state_in = 3'd1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++;
                $display("FAIL hit_place cyc=%0d got=%h required=%h", cyc, dut_vec(), model_vec());
            end
            if (placed === 1'b1) done = 1;
        end
        tests++;
        if (!(done && piece_y === 5'd4 && piece_x === 4'd4)) begin
            fails++;
            $display("FAIL hit_lock got placed=%b (%0d,%0d) required 1 (4,4)", done, piece_x, piece_y);
        end
        clear_board();
    endtask

    task automatic test_game_over();
        int reqs = 0;
        clear_board();
        blocked[4][0] = 1;
        do_restart();
        state_in = 3'd1;
        for (int i = 0; i < 4; i++) step();
        tests++;
        if (game_over !== 1'b1 || placed !== 1'b0) begin
            fails++;
            $display("FAIL game_over_set got go=%b placed=%b required go=1 placed=0", game_over, placed);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (chk_req !== 1'b0 || game_over !== 1'b1) reqs++;
        end
        tests++;
        if (reqs != 0) begin
            fails++;
            $display("FAIL game_over_sticky got %0d bad cycles required 0", reqs);
        end
        do_restart();
        tests++;
        if (game_over !== 1'b0) begin
            fails++;
            $display("FAIL game_over_clear got=%b required=0", game_over);
        end
        clear_board();
    endtask

    task automatic test_moves();
        bit ok;
        int n;
        clear_board();
        do_restart();
        state_in = 3'd1;
        wait_fall(0, ok);
        ml = 1'b1;
        step();
        tests++;
        if (!(ok && chk_req === 1'b1 && chk_x === 4'd3 && chk_y === 5'd0)) begin
            fails++;
            $display("FAIL left_query got=%b(%0d,%0d) required=1(3,0)", chk_req, chk_x, chk_y);
        end
        for (int i = 0; i < 5 && chk_req === 1'b1; i++) step();
        tests++;
        if (piece_x !== 4'd3) begin
            fails++;
            $display("FAIL left_commit got=%0d required=3", piece_x);
        end
        ml = 1'b1;
        mr = 1'b1;
        step();
        tests++;
        if (!(chk_req === 1'b0 && piece_x === 4'd3)) begin
            fails++;
            $display("FAIL both_moves got req=%b x=%0d required req=0 x=3", chk_req, piece_x);
        end
        wait_fall(TICK - 1, ok);
        ml = 1'b1;
        step();
        tests++;
        if (!(ok && chk_req === 1'b1 && chk_x === 4'd3 && chk_y === 5'd1)) begin
            fails++;
            $display("FAIL tick_beats_move got=%b(%0d,%0d) required=1(3,1)", chk_req, chk_x, chk_y);
        end
        n = 0;
        while (piece_x !== 4'd0 && n < 300) begin
            if (m_phase == M_FALLING && m_ticks < TICK - 1) ml = 1'b1;
            step();
            n++;
        end
        wait_fall(0, ok);
        ml = 1'b1;
        step();
        tests++;
        if (!(ok && piece_x === 4'd0 && chk_req === 1'b0)) begin
            fails++;
            $display("FAIL left_wall got x=%0d req=%b required x=0 req=0", piece_x, chk_req);
        end
    endtask

    task automatic test_abort();
        int rx, ry;
        bit ok = 0;
        int bad = 0;
        clear_board();
        do_restart();
        state_in = 3'd1;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (m_phase == M_WAIT_DROP) ok = 1;
        end
        rx = m_x;
        ry = m_y;
        state_in = 3'd0;
        step();
        tests++;
        if (!(ok && chk_req === 1'b1 && chk_y === 5'(ry + 1))) begin
            fails++;
            $display("FAIL abort_hold got req=%b y=%0d required req=1 y=%0d", chk_req, chk_y, ry + 1);
        end
        step();
        tests++;
        if (!(chk_req === 1'b0 && piece_x === 4'(rx) && piece_y === 5'(ry))) begin
            fails++;
            $display("FAIL abort_discard got req=%b (%0d,%0d) required 0 (%0d,%0d)",
                     chk_req, piece_x, piece_y, rx, ry);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (chk_req !== 1'b0 || piece_y !== 5'(ry)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL abort_idle got %0d bad cycles required 0", bad);
        end
        state_in = 3'd1;
        step();
        tests++;
        if (!(chk_req === 1'b1 && chk_x === 4'd4 && chk_y === 5'd0)) begin
            fails++;
            $display("FAIL resume_spawn got=%b(%0d,%0d) required=1(4,0)", chk_req, chk_x, chk_y);
        end
        do_restart();
        tests++;
        if (chk_req !== 1'b0) begin
            fails++;
            $display("FAIL restart_drop_req got=%b required=0", chk_req);
        end
        state_in = 3'd0;
        stray_ack = 1;
        step();
        tests++;
        if (dut_vec() !== model_vec() || chk_req !== 1'b0 || piece_y !== 5'd0) begin
            fails++;
            $display("FAIL stray_ack got=%h required=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        clear_board();
        for (int x = 0; x < BW; x++)
            for (int y = 2; y < BH; y++)
                blocked[x][y] = ($urandom_range(0, 9) == 0);
        do_restart();
        state_in = 3'd1;
        for (int i = 0; i < 3000; i++) begin
            ml = ($urandom_range(0, 3) == 0);
            mr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0)
                state_in = (state_in == 3'd1) ? 3'($urandom_range(0, 7)) : 3'd1;
            restart = ($urandom_range(0, 299) == 0);
            stray_ack = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) blocked[4][0] = ~blocked[4][0];
            step();
            restart = 1'b0;
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%h required=%h", cyc, dut_vec(), model_vec());
            end
            if (game_over === 1'b1 && $urandom_range(0, 9) == 0) begin
                blocked[4][0] = 0;
                restart = 1'b1;
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_fall();
        test_hit_place();
        test_game_over();
        test_moves();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
